// File: rtl/divisor_seq_if.sv
// ----------------------------------------------------------------------------
// divisor_seq_if
// Start/done handshake and operand/result bundle for the sequential divider.
//   start      : request a division (driven by master)
//   entryA     : 16-bit unsigned dividend (driven by master)
//   entryB     : 8-bit unsigned divisor (driven by master)
//   busy       : high while the divider iterates (driven by slave)
//   done       : one-cycle completion pulse (driven by slave)
//   quotient   : 16-bit result (driven by slave)
//   remainder  : 8-bit result (driven by slave)
//   div_zero   : divisor-was-zero flag (driven by slave)
// Modports: master = requester side, slave = divider side.
// ----------------------------------------------------------------------------
interface divisor_seq_if;
    logic        start;
    logic [15:0] entryA;
    logic [7:0]  entryB;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    modport master (
        output start, entryA, entryB,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, entryA, entryB,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/divisor_seq.sv
// ----------------------------------------------------------------------------
// divisor_seq
// Sequential unsigned restoring divider, 16-bit dividend / 8-bit divisor,
// one quotient bit retired per clock. Sixteen CALC cycles followed by a
// single DONE cycle carrying the done pulse.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : divisor_seq_if.slave (start/entryA/entryB in,
//            busy/done/quotient/remainder/div_zero out)
//
// Build option:
//   DIVISOR_ZERO_DETECT_EN - when defined, a zero divisor bypasses CALC,
//   goes straight to DONE and raises div_zero. When undefined, a zero
//   divisor runs the normal algorithm and div_zero is tied to 0.
// ----------------------------------------------------------------------------
module divisor_seq (
    input  logic          clk,
    input  logic          rst_n,
    divisor_seq_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_reg,     state_next;
    logic [15:0] q_reg,         q_next;
    logic [7:0]  d_reg,         d_next;
    logic [8:0]  r_reg,         r_next;
    logic [4:0]  cnt_reg,       cnt_next;
    logic [15:0] quotient_reg,  quotient_next;
    logic [7:0]  remainder_reg, remainder_next;

    // One restoring step. The trial difference is one bit wider than the
    // partial remainder so its top bit is a clean borrow indicator.
    logic [8:0]  rem_shift;
    logic [9:0]  trial;
    logic        qbit;
    logic [8:0]  r_step;
    logic [15:0] q_step;

    assign rem_shift = {r_reg[7:0], q_reg[15]};
    assign trial     = {1'b0, rem_shift} - {2'b00, d_reg};
    assign qbit      = ~trial[9];
    assign r_step    = qbit ? trial[8:0] : rem_shift;
    assign q_step    = {q_reg[14:0], qbit};

`ifdef DIVISOR_ZERO_DETECT_EN
    logic div_zero_reg, div_zero_next;
`endif

    always_comb begin
        state_next     = state_reg;
        q_next         = q_reg;
        d_next         = d_reg;
        r_next         = r_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
`ifdef DIVISOR_ZERO_DETECT_EN
        div_zero_next  = div_zero_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    q_next         = bus.entryA;
                    d_next         = bus.entryB;
                    r_next         = 9'd0;
                    cnt_next       = 5'd0;
                    quotient_next  = 16'h0000;
                    remainder_next = 8'h00;
                    state_next     = ST_CALC;
`ifdef DIVISOR_ZERO_DETECT_EN
                    div_zero_next  = 1'b0;
                    // Same values the full iteration would produce, one
                    // cycle instead of seventeen.
                    if (bus.entryB == 8'h00) begin
                        quotient_next  = 16'hFFFF;
                        remainder_next = bus.entryA[7:0];
                        div_zero_next  = 1'b1;
                        state_next     = ST_DONE;
                    end
`endif
                end
            end
            ST_CALC: begin
                q_next   = q_step;
                r_next   = r_step;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'd15) begin
                    // Results are loaded on the edge entering DONE so they
                    // are already valid during the done pulse.
                    quotient_next  = q_step;
                    remainder_next = r_step[7:0];
                    state_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            q_reg         <= 16'h0000;
            d_reg         <= 8'h00;
            r_reg         <= 9'd0;
            cnt_reg       <= 5'd0;
            quotient_reg  <= 16'h0000;
            remainder_reg <= 8'h00;
`ifdef DIVISOR_ZERO_DETECT_EN
            div_zero_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            q_reg         <= q_next;
            d_reg         <= d_next;
            r_reg         <= r_next;
            cnt_reg       <= cnt_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
`ifdef DIVISOR_ZERO_DETECT_EN
            div_zero_reg  <= div_zero_next;
`endif
        end
    end

    assign bus.busy      = (state_reg == ST_CALC);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
`ifdef DIVISOR_ZERO_DETECT_EN
    assign bus.div_zero  = div_zero_reg;
`else
    assign bus.div_zero  = 1'b0;
`endif

endmodule
